ones_index_stream: RTL
======================

Name: ones_index_stream

Overview:
- Companion to the ALU popcount operation: takes one 32-bit (or 16-bit, via size) operand and streams out the bit index of every set bit, lowest first, one index per handshake.
- Total beat count for a non-zero word equals that word's popcount.
- Sits beside the ALU as a multi-cycle operation: valid/ready on both input and output.
- Used by the bit-manipulation path and as a sequential cross-check of the combinational popcount result.

Parameters:
- WIDTH, 32, operand width; must be even; size=0 masks to the lower WIDTH/2 bits.
- IDX_W, $clog2(WIDTH), width of the emitted bit index.
- CNT_W, $clog2(WIDTH)+1, width of the ordinal/count fields.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand (high only in IDLE).
- size  input  1  1 = full WIDTH; 0 = lower WIDTH/2 bits only.
- inp  input  WIDTH  operand.
- out_valid  output  1  index beat available.
- out_ready  input  1  consumer accepts beat.
- out_idx  output  IDX_W  bit position of the current set bit.
- out_ord  output  CNT_W  1-based ordinal of this beat; 0 on the zero-word beat.
- out_last  output  1  final beat of this operand.
- out_zero  output  1  operand (after masking) had no set bits.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset (sampled high at a clk edge) forces:
  - state=IDLE, remaining mask=0, ordinal=0.
  - in_ready=1, out_valid=0, out_idx=0, out_ord=0, out_last=0, out_zero=0.
  - Reset mid-stream discards the operand; no further beats are emitted.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid, load mask = size ? inp : inp & lower-half mask, ordinal=1, and go to EMIT.
  - EMIT: in_ready=0, out_valid=1. Outputs are registered and stable while out_valid && !out_ready.
- EMIT outputs:
  - out_idx = index of the lowest set bit of mask.
  - out_ord = ordinal.
  - out_last = 1 when mask with that bit cleared is zero.
  - out_zero = 0.
- On out_valid && out_ready in EMIT:
  - Clear the lowest set bit and increment the ordinal.
  - If out_last, go to IDLE; otherwise stay in EMIT.
- Zero operand (masked mask==0): exactly one beat with out_zero=1, out_last=1, out_idx=0, out_ord=0, then return to IDLE.
- Latency:
  - Operand accepted at edge N gives the first beat valid after edge N.
  - With out_ready held high, one beat per cycle.
  - k set bits take k cycles in EMIT; a zero operand takes 1 cycle.
- No overlap: a new operand is accepted only in IDLE. The cycle after the last beat is accepted, in_ready=1. There is no same-cycle last-accept/new-load.
- size=0 ignores inp[WIDTH-1:WIDTH/2] entirely; indices are always < WIDTH/2.
- Maximum ordinal is WIDTH (all-ones full word) and fits in CNT_W.
- in_valid while in_ready=0 is ignored; inp and size are not sampled.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared ALU package: WIDTH default, IDX_W/CNT_W derivations, the lower-half mask constant, and the state enum type (IDLE, EMIT).
- Sub-module lsb_index: combinational lowest-set-bit priority encoder (WIDTH in, IDX_W index plus a found flag out). It is also reusable for count-trailing-zeros.
- The top holds the FSM, mask register, ordinal counter and output registers.

Test Plan:
- Reset then size=1, inp=32'h8000_0005, out_ready=1:
  - Beats (idx,ord,last) = (0,1,0), (2,2,0), (31,3,1).
  - in_ready=1 the following cycle.
- size=0, inp=32'hFFFF_0000: one beat with out_zero=1, out_last=1, out_ord=0, out_idx=0.
- size=1, inp=32'hFFFF_FFFF, out_ready=1:
  - 32 consecutive beats, idx 0..31, ord 1..32.
  - Only the beat with idx=31 has out_last=1.
- Backpressure: inp=32'h0000_0110 with out_ready low for 3 cycles:
  - out_idx=4, out_ord=1 held stable throughout.
  - After release: (4,1,0) then (8,2,1).
- rst asserted after the 2nd beat of inp=32'h0000_00FF:
  - Next cycle out_valid=0, in_ready=1.
  - New operand 32'h1 yields a single beat (0,1,1).
- in_valid pulsed with inp=32'hFFFF_FFFF during EMIT of 32'h3: ignored; only beats (0,1,0), (1,2,1) are emitted.

Source files
------------

// File: rtl/ones_index_stream_pkg.sv
// Shared ALU definitions for the set-bit index streamer: default operand width,
// derived index/count widths, the lower-half mask and the FSM state type.
package ones_index_stream_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH) + 1;

  localparam logic [DEFAULT_WIDTH-1:0] LOWER_HALF_MASK =
    {{(DEFAULT_WIDTH/2){1'b0}}, {(DEFAULT_WIDTH/2){1'b1}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/ones_index_stream_if.sv
// Operand-in / index-beat-out bus for ones_index_stream.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
interface ones_index_stream_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
);

  logic             in_valid;
  logic             in_ready;
  logic             size;
  logic [WIDTH-1:0] inp;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_ord;
  logic             out_last;
  logic             out_zero;

  // Producer of operands and consumer of beats.
  modport master (
    output in_valid, size, inp, out_ready,
    input  in_ready, out_valid, out_idx, out_ord, out_last, out_zero
  );

  // The streamer itself.
  modport slave (
    input  in_valid, size, inp, out_ready,
    output in_ready, out_valid, out_idx, out_ord, out_last, out_zero
  );

endinterface

// File: rtl/ones_index_stream_lsb_index.sv
// Lowest-set-bit priority encoder; idx is 0 and found is 0 for an all-zero
// vector, so it also serves as a count-trailing-zeros core.
module ones_index_stream_lsb_index #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ones_index_stream.sv
// Streams the bit index of every set bit of an operand, lowest first, one
// index per output handshake; a zero operand yields a single out_zero beat.
module ones_index_stream
  import ones_index_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ones_index_stream_if.slave    bus,
  output state_t                dbg_state
);

  localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] ord_q, ord_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] out_ord_q, out_ord_d;
  logic             out_last_q, out_last_d;
  logic             out_zero_q, out_zero_d;

  logic [WIDTH-1:0] load_mask;
  logic [WIDTH-1:0] cand_mask;
  logic [WIDTH-1:0] cand_rest;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;

  // cand_mask is the mask the next beat will be drawn from: the freshly loaded
  // operand in IDLE, or the current mask with its lowest bit retired in EMIT.
  always_comb begin
    load_mask = bus.size ? bus.inp : (bus.inp & LO_MASK);
    if (state_q == IDLE) begin
      cand_mask = load_mask;
    end else begin
      cand_mask = mask_q & (mask_q - WIDTH'(1));
    end
    cand_rest = cand_mask & (cand_mask - WIDTH'(1));
  end

  ones_index_stream_lsb_index #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb_index (
    .vec   (cand_mask),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ord_d      = ord_q;
    out_idx_d  = out_idx_q;
    out_ord_d  = out_ord_q;
    out_last_d = out_last_q;
    out_zero_d = out_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = EMIT;
          mask_d     = load_mask;
          ord_d      = CNT_W'(1);
          out_idx_d  = enc_idx;
          out_ord_d  = enc_found ? CNT_W'(1) : '0;
          out_last_d = (cand_rest == '0);
          out_zero_d = !enc_found;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d    = IDLE;
            mask_d     = '0;
            ord_d      = '0;
            out_idx_d  = '0;
            out_ord_d  = '0;
            out_last_d = 1'b0;
            out_zero_d = 1'b0;
          end else begin
            mask_d     = cand_mask;
            ord_d      = ord_q + CNT_W'(1);
            out_idx_d  = enc_idx;
            out_ord_d  = ord_q + CNT_W'(1);
            out_last_d = (cand_rest == '0);
            out_zero_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      ord_q      <= '0;
      out_idx_q  <= '0;
      out_ord_q  <= '0;
      out_last_q <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ord_q      <= ord_d;
      out_idx_q  <= out_idx_d;
      out_ord_q  <= out_ord_d;
      out_last_q <= out_last_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_idx   = out_idx_q;
  assign bus.out_ord   = out_ord_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_zero  = out_zero_q;
  assign dbg_state     = state_q;

endmodule
